// File: rtl/ann_stream_pkg.sv
// Shared types and helpers for the narrow/wide lane streaming stages.
// Used by both the aggregator and the disaggregator so lane geometry stays identical.
package ann_stream_pkg;

  localparam int PKG_DATA_WIDTH  = 8;
  localparam int PKG_FETCH_WIDTH = 6;
  localparam int PKG_CNT_W       = $clog2(PKG_FETCH_WIDTH + 1);

  localparam int SLICE_BUS_W  = 512;
  localparam int SLICE_LANE_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef logic [PKG_CNT_W-1:0] lane_cnt_t;

  // Callers zero-extend the word to SLICE_BUS_W and truncate the result to their lane width.
  function automatic logic [SLICE_LANE_W-1:0] lane_slice(input logic [SLICE_BUS_W-1:0] word,
                                                         input int unsigned lane,
                                                         input int unsigned lane_w);
    return SLICE_LANE_W'(word >> (lane * lane_w));
  endfunction

  function automatic logic fw_legal(input int unsigned fw, input int unsigned max_fw);
    return (fw != 0) && (fw <= max_fw);
  endfunction

endpackage

// File: rtl/wide_word_disaggregator_if.sv
// Wide sender / narrow receiver FIFO-style handshake bundle.
interface wide_word_disaggregator_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int FETCH_WIDTH = 6
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );

endinterface

// File: rtl/wide_word_disaggregator_fetch_width_ctrl.sv
// Runtime lane-count register: latches legal requests, applies them only when the datapath allows.
// A request in the same cycle as an apply survives as the next pending request.
module fetch_width_ctrl
  import ann_stream_pkg::*;
#(
  parameter int FETCH_WIDTH      = 6,
  parameter int CNT_W            = $clog2(FETCH_WIDTH + 1),
  parameter int INIT_FETCH_WIDTH = FETCH_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_fetch_width_i,
  input  logic [CNT_W-1:0] input_fetch_width_i,
  input  logic             apply_ok_i,
  output logic [CNT_W-1:0] active_fw_o,
  output logic             pending_o,
  output logic             cfg_error_o
);

  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_fw_q, pend_fw_d;
  logic             pending_q, pending_d;
  logic             cfg_error_q, cfg_error_d;
  logic             req_legal;

  assign req_legal = fw_legal(32'(input_fetch_width_i), FETCH_WIDTH);

  always_comb begin
    active_d    = active_q;
    pend_fw_d   = pend_fw_q;
    pending_d   = pending_q;
    cfg_error_d = cfg_error_q;
    if (apply_ok_i && pending_q) begin
      active_d  = pend_fw_q;
      pending_d = 1'b0;
    end
    if (change_fetch_width_i) begin
      if (req_legal) begin
        pending_d = 1'b1;
        pend_fw_d = input_fetch_width_i;
      end else begin
        cfg_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q    <= CNT_W'(INIT_FETCH_WIDTH);
      pend_fw_q   <= CNT_W'(INIT_FETCH_WIDTH);
      pending_q   <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      pend_fw_q   <= pend_fw_d;
      pending_q   <= pending_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign active_fw_o = active_q;
  assign pending_o   = pending_q;
  assign cfg_error_o = cfg_error_q;

endmodule

// File: rtl/wide_word_disaggregator.sv
// Serializes the active lanes of each wide word, lane 0 first; a popped word emits lane 0 next cycle.
// Receiver backpressure freezes the lane index; the next word is popped on the last lane for zero bubbles.
module wide_word_disaggregator
  import ann_stream_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int FETCH_WIDTH      = 6,
  parameter int CNT_W            = $clog2(FETCH_WIDTH + 1),
  parameter int INIT_FETCH_WIDTH = FETCH_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  wide_word_disaggregator_if.slave       bus,
  input  logic                           change_fetch_width,
  input  logic [CNT_W-1:0]               input_fetch_width,
  output logic [CNT_W-1:0]               active_fetch_width,
  output logic                           busy,
  output logic                           cfg_error
);

  localparam int BUS_W = FETCH_WIDTH * DATA_WIDTH;

  state_t           state_q, state_d;
  logic [BUS_W-1:0] wide_q, wide_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             pending;
  logic             last_lane;
  logic             enq;
  logic             deq;

  fetch_width_ctrl #(
    .FETCH_WIDTH      (FETCH_WIDTH),
    .CNT_W            (CNT_W),
    .INIT_FETCH_WIDTH (INIT_FETCH_WIDTH)
  ) u_fw_ctrl (
    .clk                  (clk),
    .rst                  (rst),
    .change_fetch_width_i (change_fetch_width),
    .input_fetch_width_i  (input_fetch_width),
    .apply_ok_i           (state_q == IDLE),
    .active_fw_o          (active_fetch_width),
    .pending_o            (pending),
    .cfg_error_o          (cfg_error)
  );

  assign last_lane = (idx_q == active_fetch_width - CNT_W'(1));
  assign enq       = (state_q == EMIT) && bus.receiver_full_n;
  // A pending width change blocks the reload so the new width applies between words.
  assign deq       = bus.sender_empty_n && !pending &&
                     ((state_q == IDLE) || (enq && last_lane));

  always_comb begin
    state_d = state_q;
    wide_d  = wide_q;
    idx_d   = idx_q;
    if (deq) begin
      wide_d  = bus.sender_data;
      idx_d   = '0;
      state_d = EMIT;
    end else if (enq) begin
      if (last_lane) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wide_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      wide_q  <= wide_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = DATA_WIDTH'(lane_slice(SLICE_BUS_W'(wide_q), 32'(idx_q), DATA_WIDTH));
  assign busy              = (state_q == EMIT) || pending;

endmodule

// File: tb/tb_wide_word_disaggregator.sv
// Directed bench: width changes, back-to-back streaming, stalls, illegal widths and mid-word reset.
module tb_wide_word_disaggregator;

  localparam int DW = 8;
  localparam int FW = 6;
  localparam int CW = $clog2(FW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          change_fetch_width;
  logic [CW-1:0] input_fetch_width;
  logic [CW-1:0] active_fetch_width;
  logic          busy;
  logic          cfg_error;

  int checks = 0;
  int errors = 0;

  wide_word_disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();

  wide_word_disaggregator #(
    .DATA_WIDTH       (DW),
    .FETCH_WIDTH      (FW),
    .CNT_W            (CW),
    .INIT_FETCH_WIDTH (FW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width),
    .active_fetch_width (active_fetch_width),
    .busy               (busy),
    .cfg_error          (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] inc_word(input int k);
    logic [47:0] w;
    w = '0;
    for (int l = 0; l < FW; l++) w[l*DW +: DW] = 8'(6 * k + l);
    return w;
  endfunction

  // Request a width from IDLE and wait for it to take effect.
  task automatic set_fw(input int fw);
    @(negedge clk);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(fw);
    @(negedge clk);
    change_fetch_width = 1'b0;
    #1 chk("cfg_pending_busy", 48'(busy), 48'd1);
    @(negedge clk);
    #1 chk("cfg_applied", 48'(active_fetch_width), 48'(fw));
    chk("cfg_idle_busy", 48'(busy), 48'd0);
  endtask

  initial begin
    logic [15:0] pat;
    int          n;

    rst                 = 1'b1;
    change_fetch_width  = 1'b0;
    input_fetch_width   = '0;
    bus.sender_data     = '0;
    bus.sender_empty_n  = 1'b0;
    bus.receiver_full_n = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_deq", 48'(bus.sender_deq), 48'd0);
    chk("rst_enq", 48'(bus.receiver_enq), 48'd0);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_data", 48'(bus.receiver_data), 48'd0);
    chk("rst_fw", 48'(active_fetch_width), 48'd6);
    chk("rst_cfgerr", 48'(cfg_error), 48'd0);
    rst = 1'b0;

    // fw=4: upper lanes 0xAA/0xBB must never appear
    set_fw(4);
    @(negedge clk);
    bus.sender_data    = 48'hBBAA13121110;
    bus.sender_empty_n = 1'b1;
    #1 chk("t1_pop", 48'(bus.sender_deq), 48'd1);
    chk("t1_pop_enq", 48'(bus.receiver_enq), 48'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.sender_empty_n = 1'b0;
      #1 chk("t1_enq", 48'(bus.receiver_enq), 48'd1);
      chk("t1_data", 48'(bus.receiver_data), 48'(8'h10 + i));
      chk("t1_deq", 48'(bus.sender_deq), 48'd0);
    end
    @(negedge clk);
    #1 chk("t1_idle_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t1_idle_busy", 48'(busy), 48'd0);

    // fw=6: back-to-back words give a gapless incrementing byte stream
    set_fw(6);
    @(negedge clk);
    bus.sender_data    = inc_word(0);
    bus.sender_empty_n = 1'b1;
    #1 chk("t2_pop", 48'(bus.sender_deq), 48'd1);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      bus.sender_data    = inc_word(c / 6 + 1);
      bus.sender_empty_n = (c != 17);
      #1 chk("t2_enq", 48'(bus.receiver_enq), 48'd1);
      chk("t2_data", 48'(bus.receiver_data), 48'(c));
      chk("t2_deq", 48'(bus.sender_deq), 48'(((c % 6) == 5) && (c != 17)));
    end
    @(negedge clk);
    bus.sender_empty_n = 1'b0;
    #1 chk("t2_idle_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t2_idle_busy", 48'(busy), 48'd0);

    // fw=4 with receiver stalls: lane index must hold while full
    set_fw(4);
    pat = 16'b1001_0110_0100_1101;
    @(negedge clk);
    bus.sender_data    = 48'h252423222120;
    bus.sender_empty_n = 1'b1;
    #1 chk("t3_pop", 48'(bus.sender_deq), 48'd1);
    n = 0;
    for (int c = 0; c < 16 && n < 4; c++) begin
      @(negedge clk);
      bus.sender_empty_n  = 1'b0;
      bus.receiver_full_n = pat[c];
      #1 chk("t3_enq", 48'(bus.receiver_enq), 48'(pat[c]));
      chk("t3_data", 48'(bus.receiver_data), 48'(8'h20 + n));
      if (pat[c]) n++;
    end
    @(negedge clk);
    bus.receiver_full_n = 1'b1;
    #1 chk("t3_idle_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t3_idle_busy", 48'(busy), 48'd0);

    // width change to 2 requested mid-word: old word finishes at 4 lanes
    @(negedge clk);
    bus.sender_data    = 48'h353433323130;
    bus.sender_empty_n = 1'b1;
    #1 chk("t4_pop", 48'(bus.sender_deq), 48'd1);
    @(negedge clk);
    bus.sender_data = 48'h454443424140;
    #1 chk("t4_l0", 48'(bus.receiver_data), 48'h30);
    chk("t4_l0_deq", 48'(bus.sender_deq), 48'd0);
    @(negedge clk);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(2);
    #1 chk("t4_l1", 48'(bus.receiver_data), 48'h31);
    @(negedge clk);
    change_fetch_width = 1'b0;
    #1 chk("t4_l2", 48'(bus.receiver_data), 48'h32);
    chk("t4_l2_busy", 48'(busy), 48'd1);
    @(negedge clk);
    #1 chk("t4_l3", 48'(bus.receiver_data), 48'h33);
    chk("t4_l3_enq", 48'(bus.receiver_enq), 48'd1);
    chk("t4_l3_noreload", 48'(bus.sender_deq), 48'd0);
    @(negedge clk);
    #1 chk("t4_apply_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t4_apply_deq", 48'(bus.sender_deq), 48'd0);
    chk("t4_apply_oldfw", 48'(active_fetch_width), 48'd4);
    @(negedge clk);
    #1 chk("t4_newfw", 48'(active_fetch_width), 48'd2);
    chk("t4_pop2", 48'(bus.sender_deq), 48'd1);
    @(negedge clk);
    bus.sender_data = 48'h555453525150;
    #1 chk("t4_w2_l0", 48'(bus.receiver_data), 48'h40);
    chk("t4_w2_l0_deq", 48'(bus.sender_deq), 48'd0);
    @(negedge clk);
    #1 chk("t4_w2_l1", 48'(bus.receiver_data), 48'h41);
    chk("t4_w2_reload", 48'(bus.sender_deq), 48'd1);
    @(negedge clk);
    bus.sender_empty_n = 1'b0;
    #1 chk("t4_w3_l0", 48'(bus.receiver_data), 48'h50);
    @(negedge clk);
    #1 chk("t4_w3_l1", 48'(bus.receiver_data), 48'h51);
    chk("t4_w3_l1_deq", 48'(bus.sender_deq), 48'd0);
    @(negedge clk);
    #1 chk("t4_idle_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t4_idle_busy", 48'(busy), 48'd0);

    // illegal widths 0 and 7: sticky error, width and traffic untouched
    @(negedge clk);
    change_fetch_width = 1'b1;
    input_fetch_width  = CW'(0);
    #1 chk("t5_pre_err", 48'(cfg_error), 48'd0);
    @(negedge clk);
    input_fetch_width = CW'(7);
    #1 chk("t5_err0", 48'(cfg_error), 48'd1);
    @(negedge clk);
    change_fetch_width = 1'b0;
    #1 chk("t5_err7", 48'(cfg_error), 48'd1);
    chk("t5_fw", 48'(active_fetch_width), 48'd2);
    chk("t5_nopend", 48'(busy), 48'd0);
    @(negedge clk);
    bus.sender_data    = 48'h656463626160;
    bus.sender_empty_n = 1'b1;
    #1 chk("t5_pop", 48'(bus.sender_deq), 48'd1);
    @(negedge clk);
    bus.sender_empty_n = 1'b0;
    #1 chk("t5_l0", 48'(bus.receiver_data), 48'h60);
    @(negedge clk);
    #1 chk("t5_l1", 48'(bus.receiver_data), 48'h61);
    chk("t5_l1_enq", 48'(bus.receiver_enq), 48'd1);
    @(negedge clk);
    #1 chk("t5_idle_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t5_sticky", 48'(cfg_error), 48'd1);

    // reset during lane 2 discards the word and restores defaults
    set_fw(4);
    @(negedge clk);
    bus.sender_data    = 48'h757473727170;
    bus.sender_empty_n = 1'b1;
    #1 chk("t6_pop", 48'(bus.sender_deq), 48'd1);
    @(negedge clk);
    bus.sender_empty_n = 1'b0;
    #1 chk("t6_l0", 48'(bus.receiver_data), 48'h70);
    @(negedge clk);
    #1 chk("t6_l1", 48'(bus.receiver_data), 48'h71);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t6_l2", 48'(bus.receiver_data), 48'h72);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t6_rst_enq", 48'(bus.receiver_enq), 48'd0);
    chk("t6_rst_deq", 48'(bus.sender_deq), 48'd0);
    chk("t6_rst_fw", 48'(active_fetch_width), 48'd6);
    chk("t6_rst_cfgerr", 48'(cfg_error), 48'd0);
    chk("t6_rst_busy", 48'(busy), 48'd0);
    chk("t6_rst_data", 48'(bus.receiver_data), 48'd0);
    @(negedge clk);
    bus.sender_data    = 48'h858483828180;
    bus.sender_empty_n = 1'b1;
    #1 chk("t6_pop", 48'(bus.sender_deq), 48'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.sender_empty_n = 1'b0;
      #1 chk("t6_enq", 48'(bus.receiver_enq), 48'd1);
      chk("t6_data", 48'(bus.receiver_data), 48'(8'h80 + i));
    end
    @(negedge clk);
    #1 chk("t6_idle_enq", 48'(bus.receiver_enq), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
